// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner of the serial system bus, holding each grant for a full transaction
module bus_arbiter #(
    parameter  int NUM_MASTERS = 2,
    parameter  int ADDR_BITS   = 16,
    parameter  int DATA_BITS   = 8,
    parameter  int TIMEOUT     = 255,
    localparam int GW          = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] m_req,
    output logic [NUM_MASTERS-1:0] m_grant,
    input  logic [NUM_MASTERS-1:0] m_mode,
    input  logic [NUM_MASTERS-1:0] m_wr_bus,
    input  logic [NUM_MASTERS-1:0] m_master_valid,
    input  logic [NUM_MASTERS-1:0] m_master_ready,
    output logic [NUM_MASTERS-1:0] m_rd_bus,
    output logic [NUM_MASTERS-1:0] m_slave_ready,
    output logic [NUM_MASTERS-1:0] m_slave_valid,
    output logic                   mode,
    output logic                   wr_bus,
    output logic                   master_valid,
    output logic                   master_ready,
    input  logic                   rd_bus,
    input  logic                   slave_ready,
    input  logic                   slave_valid,
    output logic [GW-1:0]          grant_id,
    output logic                   busy,
    output logic                   timeout
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_GRANT = 3'd1;
    localparam logic [2:0] S_ADDR  = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_REL   = 3'd4;

    logic [2:0]             r_state;
    logic [2:0]             w_next;
    logic [NUM_MASTERS-1:0] r_grant;
    logic [GW-1:0]          r_gid;
    logic [4:0]             r_beat;
    logic [7:0]             r_stall;
    logic                   r_tmode;
    logic                   r_timeout;
    logic [GW-1:0]          w_lo;
    logic [GW-1:0]          w_hi;
    logic                   w_has_hi;
    logic [GW-1:0]          w_pick;
    logic [NUM_MASTERS-1:0] w_onehot;
    logic                   w_act;
    logic                   w_beat;
    logic                   w_hit;

    // round-robin pick: lowest requester above the last grant, else the lowest requester overall
    always_comb begin
        w_lo     = '0;
        w_hi     = '0;
        w_has_hi = 1'b0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (m_req[i]) w_lo = GW'(i);
            if (m_req[i] && i > int'(r_gid)) begin
                w_hi     = GW'(i);
                w_has_hi = 1'b1;
            end
        end
    end

    assign w_pick   = w_has_hi ? w_hi : w_lo;
    assign w_onehot = NUM_MASTERS'(1) << w_pick;

    // mux is driven from registered state so the bus sees no extra arbitration delay
    assign w_act        = (r_state == S_GRANT) || (r_state == S_ADDR) || (r_state == S_DATA);
    assign mode         = w_act & m_mode[r_gid];
    assign wr_bus       = w_act & m_wr_bus[r_gid];
    assign master_valid = w_act & m_master_valid[r_gid];
    assign master_ready = w_act & m_master_ready[r_gid];
    assign m_rd_bus      = w_act ? (NUM_MASTERS'(rd_bus) << r_gid) : '0;
    assign m_slave_ready = w_act ? (NUM_MASTERS'(slave_ready) << r_gid) : '0;
    assign m_slave_valid = w_act ? (NUM_MASTERS'(slave_valid) << r_gid) : '0;
    assign m_grant  = r_grant;
    assign grant_id = r_gid;
    assign busy     = r_state != S_IDLE;
    assign timeout  = r_timeout;

    // data beats follow the direction latched at the end of the address phase
    assign w_beat = (r_state == S_DATA && !r_tmode) ? (slave_valid & master_ready)
                                                    : (master_valid & slave_ready);
    assign w_hit  = w_act && !w_beat && (r_stall == 8'(TIMEOUT));

    // transaction sequencing; a beat always takes precedence over abandon and watchdog
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = |m_req ? S_GRANT : S_IDLE;
            S_GRANT: w_next = w_beat ? S_ADDR : (!m_req[r_gid] || w_hit) ? S_REL : S_GRANT;
            S_ADDR:  w_next = (w_beat && r_beat == 5'(ADDR_BITS - 1)) ? S_DATA : w_hit ? S_REL : S_ADDR;
            S_DATA:  w_next = (w_beat && r_beat == 5'(DATA_BITS - 1)) ? S_REL : w_hit ? S_REL : S_DATA;
            S_REL:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // state, grant, beat counting and stall watchdog registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_grant   <= '0;
            r_gid     <= GW'(NUM_MASTERS - 1);
            r_beat    <= '0;
            r_stall   <= '0;
            r_tmode   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_grant   <= (w_next == S_GRANT || w_next == S_ADDR || w_next == S_DATA)
                         ? ((r_state == S_IDLE) ? w_onehot : r_grant) : '0;
            r_gid     <= (r_state == S_IDLE && |m_req) ? w_pick : r_gid;
            r_beat    <= !w_act ? '0 : !w_beat ? r_beat
                         : (r_state != S_GRANT && w_next != r_state) ? '0 : r_beat + 5'd1;
            r_stall   <= (!w_act || w_beat || w_next != r_state) ? '0 : r_stall + 8'd1;
            r_tmode   <= (r_state == S_ADDR && w_next == S_DATA) ? mode : r_tmode;
            r_timeout <= w_hit;
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed transactions with a transaction scoreboard checked by a bus monitor
module tb_bus_arbiter;
    localparam int N  = 2;
    localparam int AB = 16;
    localparam int DB = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [N-1:0] m_req = '0, m_mode = '0, m_wr_bus = '0, m_master_valid = '0, m_master_ready = '0;
    logic [N-1:0] m_grant, m_rd_bus, m_slave_ready, m_slave_valid;
    logic mode, wr_bus, master_valid, master_ready;
    logic rd_bus = 1'b0, slave_ready = 1'b0, slave_valid = 1'b0;
    logic [$clog2(N)-1:0] grant_id;
    logic busy, timeout;
    logic gap_sv = 1'b0;
    int total = 0;
    int bad = 0;

    typedef struct {int gid; int ac; int dc; int to; int rel;} txn_t;
    txn_t exp_q[$];

    bus_arbiter #(.NUM_MASTERS(N), .ADDR_BITS(AB), .DATA_BITS(DB), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .m_req(m_req), .m_grant(m_grant), .m_mode(m_mode),
        .m_wr_bus(m_wr_bus), .m_master_valid(m_master_valid), .m_master_ready(m_master_ready),
        .m_rd_bus(m_rd_bus), .m_slave_ready(m_slave_ready), .m_slave_valid(m_slave_valid),
        .mode(mode), .wr_bus(wr_bus), .master_valid(master_valid), .master_ready(master_ready),
        .rd_bus(rd_bus), .slave_ready(slave_ready), .slave_valid(slave_valid),
        .grant_id(grant_id), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic expire(input string nm);
        total++;
        bad++;
        $display("FAIL %s: bound expired", nm);
    endtask

    task automatic wait_grant();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (m_grant != '0) return;
        end
        expire("wait_grant");
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        expire("wait_idle");
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_grant", m_grant, 0);
        chk("rst_gid", grant_id, N - 1);
        chk("rst_busy", busy, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_bus", {mode, wr_bus, master_valid, master_ready}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // free-running serial data and optional every-other-cycle slave_valid
    initial forever begin
        @(posedge clk); #1;
        rd_bus      = 1'($urandom);
        m_wr_bus    = N'($urandom);
        slave_valid = gap_sv & ~slave_valid;
    end

    // monitor: mux checks every cycle, beat accounting per transaction, scoreboard pop at busy fall
    initial begin
        int ac, dc, to, rel, cur_gid;
        logic pbusy, tm;
        logic [N-1:0] pgrant;
        txn_t e;
        ac = 0; dc = 0; to = 0; rel = 0; cur_gid = 0; pbusy = 1'b0; tm = 1'b0; pgrant = '0;
        forever begin
            @(negedge clk);
            chk("bus_mux", {mode, wr_bus, master_valid, master_ready},
                {|(m_grant & m_mode), |(m_grant & m_wr_bus), |(m_grant & m_master_valid), |(m_grant & m_master_ready)});
            chk("resp_mux", {m_rd_bus, m_slave_ready, m_slave_valid},
                {m_grant & {N{rd_bus}}, m_grant & {N{slave_ready}}, m_grant & {N{slave_valid}}});
            chk("grant_onehot", int'($countones(m_grant) <= 1), 1);
            if (m_grant != '0) chk("grant_id_match", m_grant, N'(1) << grant_id);
            if (pgrant == '0 && m_grant != '0) begin
                for (int i = 0; i < N; i++) if (m_grant[i]) cur_gid = i;
                ac = 0; dc = 0; to = 0; rel = 0; tm = 1'b0;
            end
            if (m_grant != '0) begin
                if (ac < AB) begin
                    if (master_valid && slave_ready) begin
                        ac++;
                        if (ac == AB) tm = mode;
                    end
                end else if (tm ? (master_valid && slave_ready) : (slave_valid && master_ready)) dc++;
            end
            if (busy && m_grant == '0) rel++;
            if (timeout) to++;
            if (pbusy && !busy) begin
                if (exp_q.size() == 0) expire("unexpected_txn");
                else begin
                    e = exp_q.pop_front();
                    chk("txn_gid", cur_gid, e.gid);
                    chk("txn_addr_beats", ac, e.ac);
                    chk("txn_data_beats", dc, e.dc);
                    chk("txn_timeouts", to, e.to);
                    chk("txn_release", rel, e.rel);
                end
            end
            pbusy  = busy;
            pgrant = m_grant;
        end
    end

    initial begin
        #1 rst = 1'b1;
        #30;
        do_reset();

        // first grant after reset is master 0; write of 16+8 beats
        m_master_valid = 2'b11; m_mode = 2'b11; slave_ready = 1'b1;
        exp_q.push_back('{0, AB, DB, 0, 1});
        @(posedge clk); #1;
        m_req = 2'b01;
        @(negedge clk);
        chk("grant_not_yet", m_grant, 0);
        @(negedge clk);
        chk("grant_one_cycle", m_grant, 1);
        begin
            int nb;
            nb = 1;
            @(posedge clk); #1;
            m_req = 2'b00;
            for (int i = 0; i < 100 && busy; i++) begin
                @(negedge clk);
                if (busy) nb++;
            end
            chk("busy_cycles", nb, 26 - 1);
        end
        wait_idle();
        chk("gid_after_t1", grant_id, 0);

        // rotation with both requesting
        do_reset();
        exp_q.push_back('{0, AB, DB, 0, 1});
        exp_q.push_back('{1, AB, DB, 0, 1});
        exp_q.push_back('{0, AB, DB, 0, 1});
        m_req = 2'b11;
        for (int k = 0; k < 3; k++) begin
            wait_grant();
            if (k == 2) begin
                @(posedge clk); #1;
                m_req = 2'b00;
            end
            wait_idle();
        end

        // master 1 read with gapped slave_valid
        m_mode = 2'b01; m_master_valid = 2'b10; m_master_ready = 2'b10; gap_sv = 1'b1;
        exp_q.push_back('{1, AB, DB, 0, 1});
        m_req = 2'b10;
        wait_grant();
        @(posedge clk); #1;
        m_req = 2'b00;
        for (int i = 0; i < 200 && busy; i++) begin
            @(negedge clk);
            chk("sv0_quiet", m_slave_valid[0], 0);
        end
        gap_sv = 1'b0;
        wait_idle();

        // stall after address beat 5, watchdog frees the bus, waiting master 1 follows
        m_mode = 2'b11; m_master_valid = 2'b11; m_master_ready = 2'b00;
        exp_q.push_back('{0, 5, 0, 1, 1});
        exp_q.push_back('{1, AB, DB, 0, 1});
        m_req = 2'b01;
        wait_grant();
        @(posedge clk); #1;
        m_req = 2'b10;
        repeat (4) @(posedge clk);
        #1 slave_ready = 1'b0;
        begin
            int early, seen;
            early = 0; seen = 0;
            for (int i = 0; i < 255; i++) begin
                @(negedge clk);
                if (timeout) early++;
            end
            chk("no_early_timeout", early, 0);
            for (int i = 0; i < 4 && seen == 0; i++) begin
                @(negedge clk);
                if (timeout) seen = 1;
            end
            chk("timeout_fired", seen, 1);
        end
        @(posedge clk); #1;
        slave_ready = 1'b1;
        wait_idle();
        wait_grant();
        @(posedge clk); #1;
        m_req = 2'b00;
        wait_idle();

        // abandon before the first beat, master 1 granted next
        do_reset();
        m_master_valid = 2'b00;
        exp_q.push_back('{0, 0, 0, 0, 1});
        exp_q.push_back('{1, AB, DB, 0, 1});
        m_req = 2'b01;
        wait_grant();
        @(posedge clk); #1;
        m_req = 2'b10; m_master_valid = 2'b10;
        wait_idle();
        wait_grant();
        @(posedge clk); #1;
        m_req = 2'b00;
        wait_idle();

        // reset during data beat 3, then master 0 wins first
        m_master_valid = 2'b11;
        exp_q.push_back('{0, AB, 2, 0, 0});
        exp_q.push_back('{0, AB, DB, 0, 1});
        m_req = 2'b01;
        wait_grant();
        repeat (AB + 2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_grant", m_grant, 0);
        chk("arst_bus", {mode, wr_bus, master_valid, master_ready}, 0);
        chk("arst_busy", busy, 0);
        m_req = 2'b11;
        @(posedge clk); #1;
        rst = 1'b0;
        wait_grant();
        chk("post_rst_grant", m_grant, 1);
        @(posedge clk); #1;
        m_req = 2'b00;
        wait_idle();

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
